// File: rtl/axi4_mem_master_bridge_if.sv
`timescale 1ns/1ps
// AXI4 bus bundle between the memory bridge (master) and the interconnect/RAM responder (slave).
// A transfer occurs on a rising clk edge where VALID and READY are both high; once VALID rises it holds, with a stable payload, until that edge.
interface axi4_mem_master_bridge_if;
  logic [7:0]  axi_awid_o;
  logic [31:0] axi_awaddr_o;
  logic [7:0]  axi_awlen_o;
  logic [1:0]  axi_awburst_o;
  logic        axi_awvalid_o;
  logic        axi_awready_i;
  logic [31:0] axi_wdata_o;
  logic [3:0]  axi_wstrb_o;
  logic        axi_wlast_o;
  logic        axi_wvalid_o;
  logic        axi_wready_i;
  logic [7:0]  axi_bid_i;
  logic [1:0]  axi_bresp_i;
  logic        axi_bvalid_i;
  logic        axi_bready_o;
  logic [7:0]  axi_arid_o;
  logic [31:0] axi_araddr_o;
  logic [7:0]  axi_arlen_o;
  logic [1:0]  axi_arburst_o;
  logic        axi_arvalid_o;
  logic        axi_arready_i;
  logic [7:0]  axi_rid_i;
  logic [31:0] axi_rdata_i;
  logic [1:0]  axi_rresp_i;
  logic        axi_rlast_i;
  logic        axi_rvalid_i;
  logic        axi_rready_o;

  modport master (
    output axi_awid_o, axi_awaddr_o, axi_awlen_o, axi_awburst_o, axi_awvalid_o,
    input  axi_awready_i,
    output axi_wdata_o, axi_wstrb_o, axi_wlast_o, axi_wvalid_o,
    input  axi_wready_i,
    input  axi_bid_i, axi_bresp_i, axi_bvalid_i,
    output axi_bready_o,
    output axi_arid_o, axi_araddr_o, axi_arlen_o, axi_arburst_o, axi_arvalid_o,
    input  axi_arready_i,
    input  axi_rid_i, axi_rdata_i, axi_rresp_i, axi_rlast_i, axi_rvalid_i,
    output axi_rready_o
  );

  modport slave (
    input  axi_awid_o, axi_awaddr_o, axi_awlen_o, axi_awburst_o, axi_awvalid_o,
    output axi_awready_i,
    input  axi_wdata_o, axi_wstrb_o, axi_wlast_o, axi_wvalid_o,
    output axi_wready_i,
    output axi_bid_i, axi_bresp_i, axi_bvalid_i,
    input  axi_bready_o,
    input  axi_arid_o, axi_araddr_o, axi_arlen_o, axi_arburst_o, axi_arvalid_o,
    output axi_arready_i,
    output axi_rid_i, axi_rdata_i, axi_rresp_i, axi_rlast_i, axi_rvalid_i,
    input  axi_rready_o
  );
endinterface

// File: rtl/axi4_mem_master_bridge.sv
`timescale 1ns/1ps
// Single-outstanding AXI4 initiator: CPU/cache memory requests become single-beat writes
// or INCR read bursts; every AXI-facing output and every resp_* output is registered.
module axi4_mem_master_bridge #(
  parameter logic [7:0] AXI_ID = 8'd0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_rd_i,
  input  logic [3:0]  req_wr_i,
  input  logic [31:0] req_addr_i,
  input  logic [7:0]  req_len_i,
  input  logic [31:0] req_wdata_i,
  output logic        req_accept_o,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_last_o,
  output logic        resp_error_o,
  output logic [2:0]  dbg_state_o,
  axi4_mem_master_bridge_if.master axi
);

  typedef enum logic [2:0] {S_IDLE, S_WR_REQ, S_WR_RESP, S_RD_ADDR, S_RD_DATA} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, resp_rdata_q, resp_rdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [7:0]  len_q, len_d, beat_q, beat_d;
  logic        awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
  logic        bready_q, bready_d, rready_q, rready_d;
  logic        resp_valid_q, resp_valid_d, resp_last_q, resp_last_d, resp_error_q, resp_error_d;
  logic        aw_hs, w_hs, unused_sigs;

  assign aw_hs = awvalid_q & axi.axi_awready_i;
  assign w_hs  = wvalid_q & axi.axi_wready_i;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    len_d        = len_q;
    beat_d       = beat_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    arvalid_d    = arvalid_q;
    bready_d     = bready_q;
    rready_d     = rready_q;
    resp_valid_d = 1'b0;
    resp_last_d  = 1'b0;
    resp_error_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    req_accept_o = (state_q == S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (req_wr_i != 4'b0000) begin
          addr_d    = {req_addr_i[31:2], 2'b00};
          wdata_d   = req_wdata_i;
          wstrb_d   = req_wr_i;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = S_WR_REQ;
        end else if (req_rd_i) begin
          addr_d    = {req_addr_i[31:2], 2'b00};
          len_d     = req_len_i;
          beat_d    = 8'd0;
          arvalid_d = 1'b1;
          state_d   = S_RD_ADDR;
        end
      end
      S_WR_REQ: begin
        // AW and W complete independently; leave only once neither is still pending.
        if (aw_hs) awvalid_d = 1'b0;
        if (w_hs)  wvalid_d  = 1'b0;
        if ((!awvalid_q || aw_hs) && (!wvalid_q || w_hs)) begin
          bready_d = 1'b1;
          state_d  = S_WR_RESP;
        end
      end
      S_WR_RESP: begin
        if (axi.axi_bvalid_i) begin
          bready_d     = 1'b0;
          resp_valid_d = 1'b1;
          resp_last_d  = 1'b1;
          resp_error_d = axi.axi_bresp_i[1];
          state_d      = S_IDLE;
        end
      end
      S_RD_ADDR: begin
        if (axi.axi_arready_i) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        if (axi.axi_rvalid_i) begin
          resp_valid_d = 1'b1;
          resp_rdata_d = axi.axi_rdata_i;
          resp_last_d  = axi.axi_rlast_i;
          // Flag a burst whose length disagrees with the request: early/late rlast, or missing rlast at beat len.
          resp_error_d = axi.axi_rresp_i[1] |
                         (axi.axi_rlast_i & (beat_q != len_q)) |
                         (!axi.axi_rlast_i & (beat_q == len_q));
          beat_d       = beat_q + 8'd1;
          if (axi.axi_rlast_i) begin
            rready_d = 1'b0;
            state_d  = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      len_q        <= '0;
      beat_q       <= '0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      bready_q     <= 1'b0;
      rready_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_last_q  <= 1'b0;
      resp_error_q <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      len_q        <= len_d;
      beat_q       <= beat_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      arvalid_q    <= arvalid_d;
      bready_q     <= bready_d;
      rready_q     <= rready_d;
      resp_valid_q <= resp_valid_d;
      resp_last_q  <= resp_last_d;
      resp_error_q <= resp_error_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign axi.axi_awid_o    = AXI_ID;
  assign axi.axi_awaddr_o  = addr_q;
  assign axi.axi_awlen_o   = 8'd0;
  assign axi.axi_awburst_o = 2'b01;
  assign axi.axi_awvalid_o = awvalid_q;
  assign axi.axi_wdata_o   = wdata_q;
  assign axi.axi_wstrb_o   = wstrb_q;
  assign axi.axi_wlast_o   = 1'b1;
  assign axi.axi_wvalid_o  = wvalid_q;
  assign axi.axi_bready_o  = bready_q;
  assign axi.axi_arid_o    = AXI_ID;
  assign axi.axi_araddr_o  = addr_q;
  assign axi.axi_arlen_o   = len_q;
  assign axi.axi_arburst_o = 2'b01;
  assign axi.axi_arvalid_o = arvalid_q;
  assign axi.axi_rready_o  = rready_q;

  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = resp_rdata_q;
  assign resp_last_o  = resp_last_q;
  assign resp_error_o = resp_error_q;
  assign dbg_state_o  = state_q;

  // Response IDs and the low address/resp bits carry no meaning for this bridge.
  assign unused_sigs = ^{req_addr_i[1:0], axi.axi_bid_i, axi.axi_bresp_i[0],
                         axi.axi_rid_i, axi.axi_rresp_i[0]};

endmodule

// File: tb/tb_axi4_mem_master_bridge.sv
`timescale 1ns/1ps
// Randomized bench for axi4_mem_master_bridge: an AXI responder driven from tasks, and a
// scoreboard fed by a transaction-level model of the expected resp_* pulses.
module tb_axi4_mem_master_bridge;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_rd_i;
  logic [3:0]  req_wr_i;
  logic [31:0] req_addr_i;
  logic [7:0]  req_len_i;
  logic [31:0] req_wdata_i;
  logic        req_accept_o, resp_valid_o, resp_last_o, resp_error_o;
  logic [31:0] resp_rdata_o;
  logic [2:0]  dbg_state_o;

  axi4_mem_master_bridge_if axi();

  axi4_mem_master_bridge #(.AXI_ID(8'd0)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_rd_i(req_rd_i), .req_wr_i(req_wr_i), .req_addr_i(req_addr_i),
    .req_len_i(req_len_i), .req_wdata_i(req_wdata_i), .req_accept_o(req_accept_o),
    .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o), .resp_last_o(resp_last_o),
    .resp_error_o(resp_error_o), .dbg_state_o(dbg_state_o), .axi(axi)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;
  // Expected response: {check_data, error, last, rdata}
  logic [34:0] exp_q[$];
  logic [31:0] beat_data[260];
  logic [1:0]  beat_resp[260];

  // Scoreboard: every resp_valid pulse must match the oldest expected response.
  always @(negedge clk_i) begin
    if (!rst_i && resp_valid_o) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_resp: got err=%0b last=%0b data=%h, want no response", resp_error_o, resp_last_o, resp_rdata_o);
      end else begin
        logic [34:0] e;
        e = exp_q.pop_front();
        if (resp_error_o !== e[33] || resp_last_o !== e[32] || (e[34] && resp_rdata_o !== e[31:0])) begin
          n_fail++;
          $display("FAIL resp_beat: got err=%0b last=%0b data=%h, want err=%0b last=%0b data=%h",
                   resp_error_o, resp_last_o, resp_rdata_o, e[33], e[32], e[31:0]);
        end
      end
    end
  end

  // Read model: beats 0..rlast_at are returned; an rlast that does not land on beat len
  // marks the terminating beat, and beat len is marked when rlast has not arrived by then.
  function automatic void model_read(input int len, input int rlast_at);
    for (int i = 0; i <= rlast_at; i++) begin
      logic err;
      err = beat_resp[i][1];
      if (i == rlast_at && rlast_at != len) err = 1'b1;
      if (i == len && rlast_at != len) err = 1'b1;
      exp_q.push_back({1'b1, err, (i == rlast_at), beat_data[i]});
    end
  endfunction

  task automatic drive_req(input logic rd, input logic [3:0] wr, input logic [31:0] addr,
                           input logic [7:0] len, input logic [31:0] wdata, output bit ok);
    req_rd_i = rd; req_wr_i = wr; req_addr_i = addr; req_len_i = len; req_wdata_i = wdata;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (req_accept_o) begin
        ok = 1'b1;
        @(negedge clk_i);
        break;
      end
      @(negedge clk_i);
    end
    req_rd_i = 1'b0; req_wr_i = 4'b0;
  endtask

  task automatic axi_write_slave(input int aw_dly, input int w_dly, input int b_dly, input logic [1:0] bresp,
                                 output int aw_cyc, output int w_cyc, output logic [31:0] aw_addr,
                                 output logic [31:0] w_data, output logic [3:0] w_strb, output bit stable,
                                 output bit together, output bit acc_low, output bit b_ok);
    bit aw_done, w_done, aw_hs, w_hs;
    int guard;
    aw_done = 0; w_done = 0; aw_cyc = 0; w_cyc = 0; guard = 0; stable = 1; acc_low = 1;
    together = axi.axi_awvalid_o && axi.axi_wvalid_o;
    aw_addr = axi.axi_awaddr_o; w_data = axi.axi_wdata_o; w_strb = axi.axi_wstrb_o;
    while (!(aw_done && w_done) && guard < 64) begin
      if (req_accept_o) acc_low = 0;
      aw_hs = 0; w_hs = 0;
      if (axi.axi_awvalid_o) begin
        aw_cyc++;
        if (axi.axi_awaddr_o !== aw_addr) stable = 0;
        if (!aw_done) aw_hs = (aw_cyc > aw_dly);
      end
      if (axi.axi_wvalid_o) begin
        w_cyc++;
        if (axi.axi_wdata_o !== w_data || axi.axi_wstrb_o !== w_strb) stable = 0;
        if (!w_done) w_hs = (w_cyc > w_dly);
      end
      axi.axi_awready_i = aw_hs; axi.axi_wready_i = w_hs;
      @(negedge clk_i);
      if (aw_hs) aw_done = 1;
      if (w_hs) w_done = 1;
      guard++;
    end
    axi.axi_awready_i = 0; axi.axi_wready_i = 0;
    if (!(aw_done && w_done)) stable = 0;
    repeat (b_dly) @(negedge clk_i);
    axi.axi_bvalid_i = 1; axi.axi_bresp_i = bresp;
    guard = 0;
    while (!axi.axi_bready_o && guard < 32) begin
      @(negedge clk_i);
      guard++;
    end
    b_ok = axi.axi_bready_o;
    @(negedge clk_i);
    axi.axi_bvalid_i = 0; axi.axi_bresp_i = 2'b00;
    if (axi.axi_bready_o) b_ok = 0;
  endtask

  task automatic axi_read_slave(input int ar_dly, input int rlast_at, input int max_gap,
                                output logic [31:0] ar_addr, output logic [7:0] ar_len,
                                output logic [1:0] ar_burst, output bit ar_ok, output bit r_ok);
    int guard, gap;
    guard = 0;
    while (!axi.axi_arvalid_o && guard < 32) begin
      @(negedge clk_i);
      guard++;
    end
    ar_ok = axi.axi_arvalid_o;
    ar_addr = axi.axi_araddr_o; ar_len = axi.axi_arlen_o; ar_burst = axi.axi_arburst_o;
    for (int i = 0; i < ar_dly; i++) begin
      @(negedge clk_i);
      if (!axi.axi_arvalid_o || axi.axi_araddr_o !== ar_addr || axi.axi_arlen_o !== ar_len) ar_ok = 0;
    end
    axi.axi_arready_i = 1;
    @(negedge clk_i);
    axi.axi_arready_i = 0;
    if (axi.axi_arvalid_o) ar_ok = 0;
    r_ok = 1;
    for (int i = 0; i <= rlast_at; i++) begin
      gap = $urandom_range(0, max_gap);
      if (gap > 0) begin
        axi.axi_rvalid_i = 0; axi.axi_rlast_i = 0;
        repeat (gap) @(negedge clk_i);
      end
      axi.axi_rvalid_i = 1; axi.axi_rdata_i = beat_data[i];
      axi.axi_rresp_i = beat_resp[i]; axi.axi_rlast_i = (i == rlast_at);
      if (!axi.axi_rready_o) r_ok = 0;
      @(negedge clk_i);
    end
    axi.axi_rvalid_i = 0; axi.axi_rlast_i = 0; axi.axi_rresp_i = 2'b00;
    if (axi.axi_rready_o) r_ok = 0;
  endtask

  task automatic test_reset();
    rst_i = 1;
    repeat (3) @(negedge clk_i);
    n_checks++;
    if ({axi.axi_awvalid_o, axi.axi_wvalid_o, axi.axi_arvalid_o, axi.axi_bready_o, axi.axi_rready_o,
         resp_valid_o, resp_last_o, resp_error_o} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_valids: got %b want 00000000", {axi.axi_awvalid_o, axi.axi_wvalid_o,
               axi.axi_arvalid_o, axi.axi_bready_o, axi.axi_rready_o, resp_valid_o, resp_last_o, resp_error_o});
    end
    n_checks++;
    if ({axi.axi_awaddr_o, axi.axi_wdata_o, axi.axi_wstrb_o, axi.axi_arlen_o, resp_rdata_o} !== 108'h0) begin
      n_fail++;
      $display("FAIL reset_regs: got awaddr=%h wdata=%h wstrb=%h arlen=%h rdata=%h want all 0",
               axi.axi_awaddr_o, axi.axi_wdata_o, axi.axi_wstrb_o, axi.axi_arlen_o, resp_rdata_o);
    end
    n_checks++;
    if ({axi.axi_awburst_o, axi.axi_arburst_o, axi.axi_awlen_o, axi.axi_wlast_o, axi.axi_awid_o, axi.axi_arid_o}
        !== {2'b01, 2'b01, 8'd0, 1'b1, 8'd0, 8'd0}) begin
      n_fail++;
      $display("FAIL reset_consts: got awburst=%b arburst=%b awlen=%h wlast=%b awid=%h arid=%h want 01 01 00 1 00 00",
               axi.axi_awburst_o, axi.axi_arburst_o, axi.axi_awlen_o, axi.axi_wlast_o, axi.axi_awid_o, axi.axi_arid_o);
    end
    rst_i = 0;
    @(negedge clk_i);
    n_checks++;
    if (req_accept_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_accept: got %b want 1", req_accept_o);
    end
  endtask

  task automatic test_single_write();
    bit ok, stab, tog, acc_low, b_ok;
    int awc, wc;
    logic [31:0] aa, wd;
    logic [3:0] ws;
    exp_q.push_back({1'b0, 1'b0, 1'b1, 32'h0});
    drive_req(1'b0, 4'b1100, 32'h1000_0006, 8'd9, 32'hDEAD_BEEF, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL wr_accept: got no accept want accept"); end
    axi_write_slave(0, 0, 1, 2'b00, awc, wc, aa, wd, ws, stab, tog, acc_low, b_ok);
    n_checks++;
    if ({aa, wd, ws} !== {32'h1000_0004, 32'hDEAD_BEEF, 4'b1100}) begin
      n_fail++;
      $display("FAIL wr_payload: got awaddr=%h wdata=%h wstrb=%b want 10000004 deadbeef 1100", aa, wd, ws);
    end
    n_checks++;
    if ({tog, stab, acc_low, b_ok} !== 4'b1111) begin
      n_fail++;
      $display("FAIL wr_protocol: got together=%0b stable=%0b accept_low=%0b b_ok=%0b want 1111", tog, stab, acc_low, b_ok);
    end
    n_checks++;
    if (awc != 1 || wc != 1) begin
      n_fail++;
      $display("FAIL wr_valid_cycles: got aw=%0d w=%0d want 1 1", awc, wc);
    end
    @(negedge clk_i); #1;
    n_checks++;
    if (exp_q.size() != 0 || req_accept_o !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_done: got pending=%0d accept=%b want 0 1", exp_q.size(), req_accept_o);
    end
  endtask

  task automatic test_aw_w_skew();
    bit ok, stab, tog, acc_low, b_ok;
    int awc, wc;
    logic [31:0] aa, wd, addr, data;
    logic [3:0] ws;
    for (int k = 0; k < 2; k++) begin
      addr = $urandom; data = $urandom;
      exp_q.push_back({1'b0, 1'b0, 1'b1, 32'h0});
      drive_req(1'b0, 4'b1111, addr, 8'd0, data, ok);
      // k=0: AW three cycles late; k=1: W two cycles late
      axi_write_slave(k == 0 ? 3 : 0, k == 0 ? 0 : 2, 0, 2'b01, awc, wc, aa, wd, ws, stab, tog, acc_low, b_ok);
      n_checks++;
      if (awc != (k == 0 ? 4 : 1) || wc != (k == 0 ? 1 : 3)) begin
        n_fail++;
        $display("FAIL skew_valid_cycles[%0d]: got aw=%0d w=%0d want %0d %0d", k, awc, wc, k == 0 ? 4 : 1, k == 0 ? 1 : 3);
      end
      n_checks++;
      if ({ok, stab, tog, b_ok} !== 4'b1111 || aa !== {addr[31:2], 2'b00} || wd !== data) begin
        n_fail++;
        $display("FAIL skew_protocol[%0d]: got ok=%0b stable=%0b together=%0b b_ok=%0b awaddr=%h wdata=%h want 1111 %h %h",
                 k, ok, stab, tog, b_ok, aa, wd, {addr[31:2], 2'b00}, data);
      end
      @(negedge clk_i); #1;
      n_checks++;
      if (exp_q.size() != 0) begin n_fail++; $display("FAIL skew_resp[%0d]: got pending=%0d want 0", k, exp_q.size()); end
    end
  endtask

  task automatic test_read_burst();
    bit ok, ar_ok, r_ok;
    logic [31:0] ra;
    logic [7:0] rl;
    logic [1:0] rb;
    for (int i = 0; i < 8; i++) begin beat_data[i] = i; beat_resp[i] = 2'b00; end
    model_read(7, 7);
    drive_req(1'b1, 4'b0, 32'h0000_2000, 8'd7, 32'h0, ok);
    axi_read_slave(1, 7, 2, ra, rl, rb, ar_ok, r_ok);
    n_checks++;
    if ({ra, rl, rb} !== {32'h2000, 8'd7, 2'b01}) begin
      n_fail++;
      $display("FAIL rd_addr: got araddr=%h arlen=%0d arburst=%b want 00002000 7 01", ra, rl, rb);
    end
    n_checks++;
    if ({ok, ar_ok, r_ok} !== 3'b111) begin
      n_fail++;
      $display("FAIL rd_protocol: got accept=%0b ar_ok=%0b r_ok=%0b want 111", ok, ar_ok, r_ok);
    end
    @(negedge clk_i); #1;
    n_checks++;
    if (exp_q.size() != 0 || req_accept_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rd_done: got pending=%0d accept=%b want 0 1", exp_q.size(), req_accept_o);
    end
  endtask

  task automatic test_errors();
    bit ok, stab, tog, acc_low, b_ok, ar_ok, r_ok;
    int awc, wc;
    logic [31:0] aa, wd, ra;
    logic [3:0] ws;
    logic [7:0] rl;
    logic [1:0] rb;
    int lens[3], lasts[3];
    lens[0] = 3; lasts[0] = 2;
    lens[1] = 1; lasts[1] = 3;
    lens[2] = 2; lasts[2] = 2;
    exp_q.push_back({1'b0, 1'b1, 1'b1, 32'h0});
    drive_req(1'b0, 4'b0011, $urandom, 8'd0, $urandom, ok);
    axi_write_slave(1, 1, 2, 2'b10, awc, wc, aa, wd, ws, stab, tog, acc_low, b_ok);
    @(negedge clk_i); #1;
    n_checks++;
    if (exp_q.size() != 0 || !b_ok) begin
      n_fail++;
      $display("FAIL err_bresp: got pending=%0d b_ok=%0b want 0 1", exp_q.size(), b_ok);
    end
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i <= lasts[k]; i++) begin
        beat_data[i] = $urandom;
        beat_resp[i] = (k == 2 && i == 1) ? 2'b10 : 2'b00;
      end
      model_read(lens[k], lasts[k]);
      drive_req(1'b1, 4'b0, $urandom, lens[k][7:0], 32'h0, ok);
      axi_read_slave(0, lasts[k], 1, ra, rl, rb, ar_ok, r_ok);
      @(negedge clk_i); #1;
      n_checks++;
      if (exp_q.size() != 0 || req_accept_o !== 1'b1 || rl !== lens[k][7:0] || !r_ok) begin
        n_fail++;
        $display("FAIL err_read[%0d]: got pending=%0d accept=%b arlen=%0d r_ok=%0b want 0 1 %0d 1",
                 k, exp_q.size(), req_accept_o, rl, r_ok, lens[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit stab, tog, acc_low, b_ok, ar_ok, r_ok;
    int awc, wc;
    logic [31:0] aa, wd, ra, wr_addr, rd_addr, data;
    logic [3:0] ws;
    logic [7:0] rl;
    logic [1:0] rb;
    wr_addr = $urandom; rd_addr = $urandom; data = $urandom;
    for (int i = 0; i < 3; i++) begin beat_data[i] = $urandom; beat_resp[i] = 2'b00; end
    exp_q.push_back({1'b0, 1'b0, 1'b1, 32'h0});
    req_rd_i = 1; req_wr_i = 4'b1010; req_addr_i = wr_addr; req_len_i = 8'd2; req_wdata_i = data;
    @(negedge clk_i);
    req_wr_i = 4'b0; req_addr_i = rd_addr;
    n_checks++;
    if ({axi.axi_awvalid_o, axi.axi_arvalid_o, req_accept_o} !== 3'b100) begin
      n_fail++;
      $display("FAIL prio_write_first: got awvalid=%b arvalid=%b accept=%b want 1 0 0",
               axi.axi_awvalid_o, axi.axi_arvalid_o, req_accept_o);
    end
    axi_write_slave(0, 1, 1, 2'b00, awc, wc, aa, wd, ws, stab, tog, acc_low, b_ok);
    n_checks++;
    if ({req_accept_o, resp_valid_o, acc_low} !== 3'b111 || aa !== {wr_addr[31:2], 2'b00} || ws !== 4'b1010) begin
      n_fail++;
      $display("FAIL b2b_reaccept: got accept=%b resp_valid=%b accept_low=%b awaddr=%h wstrb=%b want 1 1 1 %h 1010",
               req_accept_o, resp_valid_o, acc_low, aa, ws, {wr_addr[31:2], 2'b00});
    end
    model_read(2, 2);
    @(negedge clk_i);
    req_rd_i = 0;
    axi_read_slave(0, 2, 0, ra, rl, rb, ar_ok, r_ok);
    @(negedge clk_i); #1;
    n_checks++;
    if (exp_q.size() != 0 || ra !== {rd_addr[31:2], 2'b00} || rl !== 8'd2 || !ar_ok) begin
      n_fail++;
      $display("FAIL b2b_read: got pending=%0d araddr=%h arlen=%0d ar_ok=%0b want 0 %h 2 1",
               exp_q.size(), ra, rl, ar_ok, {rd_addr[31:2], 2'b00});
    end
  endtask

  task automatic test_min_read_latency();
    logic [31:0] data;
    logic [3:0] seen;
    data = $urandom;
    seen = 4'b0;
    req_rd_i = 1; req_addr_i = $urandom; req_len_i = 8'd0;
    seen[0] = req_accept_o;
    @(negedge clk_i);
    req_rd_i = 0;
    seen[1] = axi.axi_arvalid_o;
    axi.axi_arready_i = 1;
    @(negedge clk_i);
    axi.axi_arready_i = 0;
    seen[2] = axi.axi_rready_o;
    axi.axi_rvalid_i = 1; axi.axi_rlast_i = 1; axi.axi_rdata_i = data; axi.axi_rresp_i = 2'b00;
    exp_q.push_back({1'b1, 1'b0, 1'b1, data});
    @(negedge clk_i);
    axi.axi_rvalid_i = 0; axi.axi_rlast_i = 0;
    seen[3] = resp_valid_o;
    n_checks++;
    if (seen !== 4'b1111) begin
      n_fail++;
      $display("FAIL min_latency: got resp,rready,arvalid,accept=%b want 1111", seen);
    end
    @(negedge clk_i); #1;
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL min_latency_resp: got pending=%0d want 0", exp_q.size()); end
  endtask

  task automatic test_long_burst();
    bit ok, ar_ok, r_ok;
    logic [31:0] ra;
    logic [7:0] rl;
    logic [1:0] rb;
    for (int i = 0; i < 256; i++) begin beat_data[i] = $urandom; beat_resp[i] = 2'b00; end
    model_read(255, 255);
    drive_req(1'b1, 4'b0, 32'h0000_3000, 8'd255, 32'h0, ok);
    axi_read_slave(0, 255, 0, ra, rl, rb, ar_ok, r_ok);
    @(negedge clk_i); #1;
    n_checks++;
    if (exp_q.size() != 0 || rl !== 8'd255 || !r_ok || req_accept_o !== 1'b1) begin
      n_fail++;
      $display("FAIL long_burst: got pending=%0d arlen=%0d r_ok=%0b accept=%b want 0 255 1 1",
               exp_q.size(), rl, r_ok, req_accept_o);
    end
  endtask

  task automatic test_random();
    bit ok, stab, tog, acc_low, b_ok, ar_ok, r_ok;
    int awc, wc, aw_dly, w_dly, len, rlast_at, r;
    logic [31:0] aa, wd, ra, addr, data;
    logic [3:0] ws, strb;
    logic [7:0] rl;
    logic [1:0] rb, bresp;
    for (int n = 0; n < 20; n++) begin
      addr = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        data = $urandom; strb = $urandom_range(1, 15); bresp = $urandom_range(0, 3);
        aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
        exp_q.push_back({1'b0, bresp[1], 1'b1, 32'h0});
        drive_req($urandom_range(0, 1) == 1, strb, addr, $urandom, data, ok);
        axi_write_slave(aw_dly, w_dly, $urandom_range(0, 3), bresp, awc, wc, aa, wd, ws, stab, tog, acc_low, b_ok);
        n_checks++;
        if ({ok, stab, tog, acc_low, b_ok} !== 5'b11111 || awc != aw_dly + 1 || wc != w_dly + 1 ||
            {aa, wd, ws} !== {addr[31:2], 2'b00, data, strb}) begin
          n_fail++;
          $display("FAIL rand_write[%0d]: got flags=%b aw=%0d w=%0d addr=%h data=%h strb=%b want 11111 %0d %0d %h %h %b",
                   n, {ok, stab, tog, acc_low, b_ok}, awc, wc, aa, wd, ws, aw_dly + 1, w_dly + 1,
                   {addr[31:2], 2'b00}, data, strb);
        end
      end else begin
        len = $urandom_range(0, 15);
        r = $urandom_range(0, 5);
        rlast_at = (r == 0) ? $urandom_range(0, len) : (r == 1) ? len + $urandom_range(1, 3) : len;
        for (int i = 0; i <= rlast_at; i++) begin
          beat_data[i] = $urandom;
          beat_resp[i] = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00;
        end
        model_read(len, rlast_at);
        drive_req(1'b1, 4'b0, addr, len[7:0], $urandom, ok);
        axi_read_slave($urandom_range(0, 3), rlast_at, 2, ra, rl, rb, ar_ok, r_ok);
        n_checks++;
        if ({ok, ar_ok, r_ok} !== 3'b111 || ra !== {addr[31:2], 2'b00} || rl !== len[7:0] || rb !== 2'b01) begin
          n_fail++;
          $display("FAIL rand_read[%0d]: got flags=%b araddr=%h arlen=%0d arburst=%b want 111 %h %0d 01",
                   n, {ok, ar_ok, r_ok}, ra, rl, rb, {addr[31:2], 2'b00}, len);
        end
      end
      @(negedge clk_i); #1;
      n_checks++;
      if (exp_q.size() != 0) begin n_fail++; $display("FAIL rand_resp[%0d]: got pending=%0d want 0", n, exp_q.size()); end
    end
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    int guard;
    for (int i = 0; i < 8; i++) begin beat_data[i] = $urandom; beat_resp[i] = 2'b00; end
    for (int i = 0; i < 2; i++) exp_q.push_back({1'b1, 1'b0, 1'b0, beat_data[i]});
    drive_req(1'b1, 4'b0, 32'h0000_4000, 8'd7, 32'h0, ok);
    guard = 0;
    while (!axi.axi_arvalid_o && guard < 32) begin @(negedge clk_i); guard++; end
    axi.axi_arready_i = 1;
    @(negedge clk_i);
    axi.axi_arready_i = 0;
    for (int i = 0; i < 3; i++) begin
      axi.axi_rvalid_i = 1; axi.axi_rdata_i = beat_data[i]; axi.axi_rresp_i = 2'b00; axi.axi_rlast_i = 0;
      if (i < 2) @(negedge clk_i);
    end
    #2 rst_i = 1;
    #1;
    n_checks++;
    if ({axi.axi_awvalid_o, axi.axi_wvalid_o, axi.axi_arvalid_o, axi.axi_bready_o, axi.axi_rready_o,
         resp_valid_o, req_accept_o} !== 7'b0000001) begin
      n_fail++;
      $display("FAIL rst_mid_burst: got aw,w,ar,b,r,resp,accept=%b want 0000001",
               {axi.axi_awvalid_o, axi.axi_wvalid_o, axi.axi_arvalid_o, axi.axi_bready_o, axi.axi_rready_o,
                resp_valid_o, req_accept_o});
    end
    axi.axi_rvalid_i = 0;
    @(negedge clk_i);
    rst_i = 0;
    @(negedge clk_i); #1;
    n_checks++;
    if (req_accept_o !== 1'b1 || resp_valid_o !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rst_recover: got accept=%b resp_valid=%b pending=%0d want 1 0 0", req_accept_o, resp_valid_o, exp_q.size());
    end
  endtask

  initial begin
    rst_i = 1; req_rd_i = 0; req_wr_i = 4'b0; req_addr_i = '0; req_len_i = '0; req_wdata_i = '0;
    axi.axi_awready_i = 0; axi.axi_wready_i = 0; axi.axi_bvalid_i = 0; axi.axi_bresp_i = 2'b00;
    axi.axi_bid_i = 8'd0; axi.axi_arready_i = 0; axi.axi_rvalid_i = 0; axi.axi_rdata_i = '0;
    axi.axi_rresp_i = 2'b00; axi.axi_rlast_i = 0; axi.axi_rid_i = 8'd0;
    test_reset();
    test_single_write();
    test_aw_w_skew();
    test_read_burst();
    test_errors();
    test_back_to_back();
    test_min_read_latency();
    test_long_burst();
    test_random();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion by 500000 ns, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
